// File: rtl/osc_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of osc_in
// over a selectable clk window, latches the result and streams it out MSB first.
module osc_freq_meter #(
  parameter int CNT_W       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       gate_sel,
  output logic [CNT_W-1:0] count_out,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic             ser_out,
  output logic             ser_valid
);

  localparam int BIT_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam int WIN_W = 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_GATE,
    S_LATCH,
    S_SHIFT
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_latch;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                 r_prev;
  logic                 w_synced;
  logic                 w_rise;

  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf_flag;
  logic [WIN_W-1:0]     r_win;
  logic [WIN_W-1:0]     w_win_last;
  logic [1:0]           r_gsel;
  logic [CNT_W-1:0]     r_shift;
  logic [BIT_W-1:0]     r_bit;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_synced & ~r_prev;

  // Window length is fixed by the gate_sel value captured in ARM.
  always_comb begin
    case (r_gsel)
      2'd0:    w_win_last = WIN_W'(255);
      2'd1:    w_win_last = WIN_W'(1023);
      2'd2:    w_win_last = WIN_W'(4095);
      default: w_win_last = WIN_W'(16383);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    busy      = (r_state != S_IDLE);
    ser_valid = (r_state == S_SHIFT);
    done      = (r_state == S_SHIFT) && (r_bit == '0);
    ser_out   = (r_state == S_SHIFT) && r_shift[CNT_W-1];
    case (r_state)
      S_IDLE:  if (start) w_next = S_ARM;
      S_ARM:   w_next = S_GATE;
      S_GATE:  if (r_win == w_win_last) w_next = S_LATCH;
      S_LATCH: begin
        w_next  = S_SHIFT;
        w_latch = 1'b1;
      end
      S_SHIFT: if (r_bit == BIT_W'(CNT_W-1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Abort wins over everything, including a pending latch.
    if (abort) begin
      w_next  = S_IDLE;
      w_latch = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= '0;
      r_prev     <= 1'b0;
      r_cnt      <= '0;
      r_ovf_flag <= 1'b0;
      r_win      <= '0;
      r_gsel     <= 2'd0;
      r_shift    <= '0;
      r_bit      <= '0;
      count_out  <= '0;
      overflow   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], osc_in};
      r_prev <= w_synced;
      case (r_state)
        S_ARM: begin
          r_cnt      <= '0;
          r_win      <= '0;
          r_ovf_flag <= 1'b0;
          r_gsel     <= gate_sel;
        end
        S_GATE: begin
          r_win <= r_win + WIN_W'(1);
          if (w_rise) begin
            if (r_cnt == {CNT_W{1'b1}}) r_ovf_flag <= 1'b1;
            else                        r_cnt      <= r_cnt + CNT_W'(1);
          end
        end
        S_SHIFT: begin
          r_shift <= {r_shift[CNT_W-2:0], 1'b0};
          r_bit   <= r_bit + BIT_W'(1);
        end
        default: ;
      endcase
      if (w_latch) begin
        count_out <= r_cnt;
        overflow  <= r_ovf_flag;
        r_shift   <= r_cnt;
        r_bit     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_osc_freq_meter.sv
// Bench for osc_freq_meter: table of gate/oscillator settings with a scoreboard
// of expected results, plus abort, reset and back-to-back sequences.
module tb_osc_freq_meter;
  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             osc_in;
  logic             start;
  logic             abort;
  logic [1:0]       gate_sel;
  logic [CNT_W-1:0] count_out;
  logic             overflow;
  logic             busy;
  logic             done;
  logic             ser_out;
  logic             ser_valid;

  int osc_half_ns = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] sel;
    int         half;
    int         exp_cnt;
    logic       exp_ovf;
  } vec_t;

  typedef struct {
    int   cnt;
    logic ovf;
    int   lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  osc_freq_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .abort(abort),
    .gate_sel(gate_sel), .count_out(count_out), .overflow(overflow),
    .busy(busy), .done(done), .ser_out(ser_out), .ser_valid(ser_valid)
  );

  always #5 clk = ~clk;

  // Oscillator toggles on multiples of 10 ns, clock edges sit at 5 mod 10.
  initial begin
    osc_in = 1'b0;
    forever begin
      if (osc_half_ns == 0) begin
        osc_in = 1'b0;
        #10;
      end else begin
        #(osc_half_ns) osc_in = ~osc_in;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int win_lat(input logic [1:0] sel);
    return (256 << (2 * int'(sel))) + 2;
  endfunction

  task automatic wait_done(input int limit, input bit poke, output int lat);
    int k;
    lat = -1;
    for (k = 1; k <= limit; k++) begin
      tick();
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      start = poke && (k % 50 == 0) && (k <= 200);
    end
    start = 1'b0;
  endtask

  task automatic run_meas(input logic [1:0] sel, input int half, input int exp_cnt,
                          input logic exp_ovf, input bit poke, input int abort_at);
    exp_t             e;
    int               lat;
    logic [CNT_W-1:0] word;
    gate_sel    = sel;
    osc_half_ns = half;
    repeat (4) tick();
    e.cnt = exp_cnt;
    e.ovf = exp_ovf;
    e.lat = win_lat(sel);
    sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    wait_done(e.lat + 20, poke, lat);
    e = sb.pop_front();
    chk("done_latency", lat, e.lat);
    if (lat < 0) return;
    chk("count_out", count_out, e.cnt);
    chk("overflow", overflow, e.ovf);
    word = '0;
    for (int b = 0; b < CNT_W; b++) begin
      if (b > 0) tick();
      chk("ser_valid_shift", ser_valid, 1);
      if (b == 1) chk("done_one_cycle", done, 0);
      word = {word[CNT_W-2:0], ser_out};
      if (b == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ser_valid", ser_valid, 0);
        chk("abort_ser_out", ser_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_count_kept", count_out, e.cnt);
        chk("abort_ovf_kept", overflow, e.ovf);
        return;
      end
    end
    tick();
    chk("busy_end", busy, 0);
    chk("ser_valid_end", ser_valid, 0);
    chk("ser_out_idle", ser_out, 0);
    chk("serial_word", word, e.cnt);
  endtask

  initial begin
    int lat;
    exp_t e;
    vecs[0] = '{sel: 2'd0, half: 40, exp_cnt: 32,   exp_ovf: 1'b0};
    vecs[1] = '{sel: 2'd1, half: 0,  exp_cnt: 0,    exp_ovf: 1'b0};
    vecs[2] = '{sel: 2'd0, half: 20, exp_cnt: 64,   exp_ovf: 1'b0};
    vecs[3] = '{sel: 2'd1, half: 80, exp_cnt: 64,   exp_ovf: 1'b0};
    vecs[4] = '{sel: 2'd3, half: 20, exp_cnt: 4095, exp_ovf: 1'b1};
    vecs[5] = '{sel: 2'd0, half: 40, exp_cnt: 32,   exp_ovf: 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; gate_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_count", count_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", done, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_ser_out", ser_out, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_meas(vecs[i].sel, vecs[i].half, vecs[i].exp_cnt, vecs[i].exp_ovf, 1'b0, -1);

    // Start pulses during GATE ignored; abort in SHIFT cycle 3.
    run_meas(2'd0, 40, 32, 1'b0, 1'b1, 3);
    tick();
    chk("abort_idle_stays", busy, 0);

    // Asynchronous reset in the middle of GATE.
    gate_sel = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_count", count_out, 0);
    chk("async_rst_ser_valid", ser_valid, 0);
    chk("async_rst_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_idle", busy, 0);
    run_meas(2'd0, 40, 32, 1'b0, 1'b0, -1);

    // Start held high: two runs, gate_sel changed mid-GATE of the first.
    gate_sel = 2'd0;
    osc_half_ns = 40;
    e.cnt = 32; e.ovf = 1'b0; e.lat = win_lat(2'd0);
    sb.push_back(e);
    start = 1'b1;
    tick();
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 100) gate_sel = 2'd3;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    gate_sel = 2'd0;
    e = sb.pop_front();
    chk("b2b_first_latency", lat, e.lat);
    chk("b2b_first_count", count_out, e.cnt);
    repeat (CNT_W - 1) tick();
    chk("b2b_last_shift", ser_valid, 1);
    tick();
    chk("b2b_gap_idle", busy, 0);
    chk("b2b_gap_ser_valid", ser_valid, 0);
    tick();
    chk("b2b_second_arm", busy, 1);
    start = 1'b0;
    sb.push_back(e);
    wait_done(400, 1'b0, lat);
    e = sb.pop_front();
    chk("b2b_second_latency", lat, e.lat);
    chk("b2b_second_count", count_out, e.cnt);
    repeat (CNT_W) tick();
    chk("b2b_end_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/osc_freq_meter.md
OSC_FREQ_METER -- requirements
Module: osc_freq_meter

Interface
REQ-001 Parameter CNT_W, default 12: edge-counter and result width, minimum 8.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on osc_in, minimum 2.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 osc_in  input  1  divided ring-oscillator signal, asynchronous to clk.
REQ-006 start  input  1  request a measurement; sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel; returns to IDLE from any state.
REQ-008 gate_sel  input  2  gate window N = 2^(8+2*gate_sel) clk cycles (256/1024/4096/16384).
REQ-009 count_out  output  CNT_W  last latched edge count.
REQ-010 overflow  output  1  count_out saturated during the last measurement.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when count_out updates.
REQ-013 ser_out  output  1  serial copy of count_out, MSB first.
REQ-014 ser_valid  output  1  ser_out carries a valid result bit.

Function
REQ-015 osc_in SHALL pass through a SYNC_STAGES flop chain; a rising edge is synced value 1 with previous synced value 0.
REQ-016 FSM states SHALL be IDLE, ARM, GATE, LATCH, SHIFT, all registered.
REQ-017 IDLE: start=1 and abort=0 -> ARM; otherwise stay.
REQ-018 ARM (1 cycle): clear edge counter, window counter and overflow flag; capture gate_sel; load edge-detect previous value with current synced value; -> GATE.
REQ-019 GATE (exactly N cycles): window counter increments each cycle; each detected rising edge increments edge counter; edge on the final GATE cycle SHALL be counted; -> LATCH when window counter reaches N-1.
REQ-020 Edge counter SHALL saturate at 2^CNT_W-1; a further edge sets the internal overflow flag and leaves the counter unchanged.
REQ-021 gate_sel changes after ARM SHALL NOT affect the running window.
REQ-022 LATCH (1 cycle): -> SHIFT; on that transition count_out <= edge counter, overflow <= flag, done = 1 for that one following cycle.
REQ-023 SHIFT (CNT_W cycles): ser_valid=1; in SHIFT cycle k (k=0..CNT_W-1) ser_out = count_out[CNT_W-1-k]; after last bit -> IDLE.
REQ-024 done and ser_valid SHALL assert in the same cycle (first SHIFT cycle).
REQ-025 Latency: start sampled at edge E0 -> done high after edge E(N+2); busy low again after edge E(N+2+CNT_W).
REQ-026 start while busy SHALL be ignored; start held high SHALL give back-to-back measurements separated by exactly one IDLE cycle.
REQ-027 abort=1 SHALL force IDLE on the next edge from any state, with priority over start; count_out and overflow keep their previous values; no done pulse; ser_valid low from the next cycle.
REQ-028 Accuracy: exact count guaranteed when osc_in high and low phases each last at least 2 clk periods; edges inside the last SYNC_STAGES cycles of the window MAY fall into no measurement.
REQ-029 ser_out SHALL be 0 whenever ser_valid is 0.

Reset
REQ-030 rst=1 SHALL immediately force IDLE and clear synchronizer, both counters, count_out, overflow, busy, done, ser_out and ser_valid to 0.
REQ-031 Reset mid-measurement SHALL discard the measurement; first start after rst deasserts begins a fresh ARM.

Verification
REQ-032 Assert rst during GATE -> same-cycle (asynchronous) busy=0, count_out=0, ser_valid=0; after release, FSM in IDLE.
REQ-033 gate_sel=0, osc_in period 8 clk (4 high/4 low), pulse start -> done at E258, count_out=32 (+/-1 by phase), overflow=0, ser_out = 000000100000 over 12 cycles.
REQ-034 osc_in held 0, gate_sel=1 -> done at E1026, count_out=0, overflow=0, 12 zero bits with ser_valid=1.
REQ-035 gate_sel=3, osc_in period 4 clk -> count_out=4095, overflow=1.
REQ-036 abort in SHIFT cycle 3 after a run giving 32 -> ser_valid=0 next cycle, count_out stays 32, busy=0; start pulses during GATE ignored.
REQ-037 start held high through two runs -> exactly one IDLE cycle between ser_valid falling and the next ARM; gate_sel changed mid-GATE has no effect on window length.
